// File: rtl/msk_share_decoder.sv
// Serial unmasking stage: folds one Boolean share per cycle into an accumulator
// and presents the recombined value on a valid/ready port.
module msk_share_decoder #(
  parameter int d     = 1,
  parameter int count = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [count*d-1:0]   in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [count-1:0]     out,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int KW = (d > 1) ? $clog2(d) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(d - 1);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t               state_q, state_d;
  logic [count*d-1:0]   share_q, share_d;
  logic [count-1:0]     acc_q, acc_d;
  logic [KW-1:0]        k_q, k_d;
  logic [count-1:0]     share0, share_k;

  // Share 0 comes straight from the input; share k is picked from the held
  // sharing with constant indices so only one share per bit is touched a cycle.
  always_comb begin
    share0  = '0;
    share_k = '0;
    for (int i = 0; i < count; i++) begin
      share0[i] = in[i*d];
      for (int j = 0; j < d; j++) begin
        if (k_q == KW'(j)) share_k[i] = share_q[i*d+j];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    share_d = share_q;
    acc_d   = acc_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d = share0;
          k_d   = KW'(1);
          if (d > 1) begin
            share_d = in;
            state_d = ACC;
          end else begin
            share_d = '0;
            state_d = OUT;
          end
        end
      end
      ACC: begin
        acc_d = acc_q ^ share_k;
        if (k_q == K_LAST) begin
          // Wipe the remaining shares the moment the value is fully recombined.
          share_d = '0;
          k_d     = '0;
          state_d = OUT;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          acc_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      share_q <= '0;
      acc_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      share_q <= share_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
    end
  end

  // The accumulator holds partial XORs in ACC; only expose it once complete.
  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = (state_q == OUT);
  assign out       = out_valid ? acc_q : '0;

endmodule

// File: tb/tb_msk_share_decoder.sv
// Bench for msk_share_decoder across four share/width configurations,
// checked against a plain XOR-reduction reference model.
module tb_msk_share_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [31:0] in_v [4];
  logic [3:0]  in_valid;
  logic [3:0]  out_ready;
  logic [3:0]  rst_n;
  logic [3:0]  ir;
  logic [3:0]  ov;
  logic [3:0]  out0;
  logic        out1;
  logic [7:0]  out2;
  logic [7:0]  out3;
  logic [7:0]  out_w [4];
  logic [3:0]  share_zero;
  logic [3:0]  acc_zero;

  msk_share_decoder #(.d(3), .count(4)) u0 (
    .clk(clk), .rst_n(rst_n[0]), .in(in_v[0][11:0]), .in_valid(in_valid[0]),
    .in_ready(ir[0]), .out(out0), .out_valid(ov[0]), .out_ready(out_ready[0]));
  msk_share_decoder #(.d(2), .count(1)) u1 (
    .clk(clk), .rst_n(rst_n[1]), .in(in_v[1][1:0]), .in_valid(in_valid[1]),
    .in_ready(ir[1]), .out(out1), .out_valid(ov[1]), .out_ready(out_ready[1]));
  msk_share_decoder #(.d(4), .count(8)) u2 (
    .clk(clk), .rst_n(rst_n[2]), .in(in_v[2][31:0]), .in_valid(in_valid[2]),
    .in_ready(ir[2]), .out(out2), .out_valid(ov[2]), .out_ready(out_ready[2]));
  msk_share_decoder #(.d(1), .count(8)) u3 (
    .clk(clk), .rst_n(rst_n[3]), .in(in_v[3][7:0]), .in_valid(in_valid[3]),
    .in_ready(ir[3]), .out(out3), .out_valid(ov[3]), .out_ready(out_ready[3]));

  always_comb begin
    out_w[0] = {4'h0, out0};
    out_w[1] = {7'h0, out1};
    out_w[2] = out2;
    out_w[3] = out3;
    share_zero = {u3.share_q == '0, u2.share_q == '0, u1.share_q == '0, u0.share_q == '0};
    acc_zero   = {u3.acc_q == '0, u2.acc_q == '0, u1.acc_q == '0, u0.acc_q == '0};
  end

  function automatic int dof(int n);
    case (n)
      0: return 3;
      1: return 2;
      2: return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int cof(int n);
    case (n)
      0: return 4;
      1: return 1;
      default: return 8;
    endcase
  endfunction

  // Reference: out[i] is the XOR of all shares of bit i.
  function automatic logic [7:0] ref_decode(int n, logic [31:0] sh);
    logic [7:0] r = '0;
    for (int i = 0; i < cof(n); i++)
      for (int j = 0; j < dof(n); j++)
        r[i] = r[i] ^ sh[i*dof(n)+j];
    return r;
  endfunction

  // Builds a packed sharing from per-share words (word j holds share j of every bit).
  function automatic logic [31:0] pack(int n, logic [7:0] w0, logic [7:0] w1,
                                       logic [7:0] w2, logic [7:0] w3);
    logic [7:0]  w [4];
    logic [31:0] r = '0;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int i = 0; i < cof(n); i++)
      for (int j = 0; j < dof(n); j++)
        r[i*dof(n)+j] = w[j][i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered and left at a negedge; accepts on the first posedge where in_ready is high.
  task automatic run_txn(input int n, input logic [31:0] sh, input int hold,
                         output int acc_cyc);
    logic [7:0] exp;
    int w;
    int lat;
    exp = ref_decode(n, sh);
    acc_cyc = -1;
    in_v[n] = sh;
    in_valid[n] = 1'b1;
    out_ready[n] = (hold == 0);
    w = 0;
    while (!ir[n] && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!ir[n]) begin
      chk("accept_timeout", {31'b0, ir[n]}, 32'd1);
      in_valid[n] = 1'b0;
      return;
    end
    acc_cyc = cyc;
    @(negedge clk);
    in_valid[n] = 1'b0;
    in_v[n] = $urandom();
    lat = 1;
    while (!ov[n] && lat < dof(n) + 3) begin
      chk("busy_in_ready", {31'b0, ir[n]}, 32'd0);
      chk("early_out", {24'b0, out_w[n]}, 32'd0);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, dof(n));
    chk("out_value", {24'b0, out_w[n]}, {24'b0, exp});
    chk("share_zeroized", {31'b0, share_zero[n]}, 32'd1);
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", {31'b0, ov[n]}, 32'd1);
      chk("hold_out", {24'b0, out_w[n]}, {24'b0, exp});
      chk("hold_in_ready", {31'b0, ir[n]}, 32'd0);
      in_valid[n] = 1'b1;
      in_v[n] = $urandom();
      @(negedge clk);
    end
    in_valid[n] = 1'b0;
    out_ready[n] = 1'b1;
    @(negedge clk);
    chk("idle_valid", {31'b0, ov[n]}, 32'd0);
    chk("idle_out", {24'b0, out_w[n]}, 32'd0);
    chk("idle_in_ready", {31'b0, ir[n]}, 32'd1);
    chk("idle_acc_clear", {31'b0, acc_zero[n]}, 32'd1);
    chk("idle_share_clear", {31'b0, share_zero[n]}, 32'd1);
  endtask

  initial begin
    int c0, c1, c2;
    logic [31:0] sh;
    for (int n = 0; n < 4; n++) in_v[n] = '0;
    in_valid  = '0;
    out_ready = '0;
    rst_n     = '0;

    // Reset held for two cycles
    repeat (2) begin
      @(negedge clk);
      for (int n = 0; n < 4; n++) chk("rst_in_ready", {31'b0, ir[n]}, 32'd0);
    end
    rst_n = 4'hF;
    #1;
    for (int n = 0; n < 4; n++) begin
      chk("post_rst_in_ready", {31'b0, ir[n]}, 32'd1);
      chk("post_rst_valid", {31'b0, ov[n]}, 32'd0);
      chk("post_rst_out", {24'b0, out_w[n]}, 32'd0);
    end
    @(negedge clk);

    // Single decode and backpressure: shares A,5,3 per nibble
    sh = pack(0, 8'hA, 8'h5, 8'h3, 8'h0);
    run_txn(0, sh, 0, c0);
    chk("single_model", {24'b0, ref_decode(0, sh)}, 32'hC);
    run_txn(0, sh, 5, c0);

    // Back-to-back stream on d=2
    run_txn(1, 32'b01, 0, c0);
    run_txn(1, 32'b11, 0, c1);
    run_txn(1, 32'b10, 0, c2);
    chk("b2b_gap1", c1 - c0, 3);
    chk("b2b_gap2", c2 - c1, 3);

    // Reset in the middle of accumulation
    in_v[2] = $urandom();
    in_valid[2] = 1'b1;
    @(negedge clk);
    in_valid[2] = 1'b0;
    @(negedge clk);
    rst_n[2] = 1'b0;
    #1;
    chk("midrst_in_ready", {31'b0, ir[2]}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("midrst_no_valid", {31'b0, ov[2]}, 32'd0);
    end
    chk("midrst_share", {31'b0, share_zero[2]}, 32'd1);
    chk("midrst_acc", {31'b0, acc_zero[2]}, 32'd1);
    rst_n[2] = 1'b1;
    @(negedge clk);
    chk("midrst_after_valid", {31'b0, ov[2]}, 32'd0);
    chk("midrst_after_out", {24'b0, out_w[2]}, 32'd0);
    run_txn(2, pack(2, 8'hFF, 8'h0F, 8'hF0, 8'h00), 0, c0);

    // Degenerate single share
    run_txn(3, 32'h5A, 0, c0);

    // Randomized traffic on every configuration
    for (int n = 0; n < 4; n++)
      for (int t = 0; t < 15; t++)
        run_txn(n, $urandom(), $urandom_range(0, 3), c0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/msk_share_decoder.md
Name: msk_share_decoder

Overview:
- Terminal unmasking stage for a d-share Boolean sharing of `count` bits, as produced by masked register pipelines.
- Accepts one sharing per valid/ready transaction and recombines it serially, XOR-ing one share per cycle into an accumulator, so no cycle combines all shares combinationally.
- Presents the unmasked value on a valid/ready output port.
- Marks the trust boundary between the masked datapath and plain consumers (e.g. ciphertext output).

Parameters:
- d, 1, number of shares per bit (>= 1).
- count, 1, number of shared bits per transaction.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- in  input  count*d  sharing; share j of bit i at index i*d+j.
- in_valid  input  1  sharing on `in` is valid.
- in_ready  output  1  decoder can accept a sharing this cycle.
- out  output  count  unmasked value, out[i] = XOR over j of in[i*d+j].
- out_valid  output  1  `out` holds a decoded value.
- out_ready  input  1  consumer accepts `out` this cycle.

Behaviour:
- Synchronous active-low reset, sampled on posedge clk.
- While rst_n is low at a posedge, the block resets to:
  - state = IDLE;
  - share register, accumulator and share counter = 0;
  - out_valid = 0 and out = 0 from the next cycle;
  - in_ready forced low combinationally while rst_n is low.
- Reset mid-operation aborts the transaction; no partial output is emitted, and share/accumulator registers are zeroed.
- States: IDLE, ACC, OUT. in_ready = (state == IDLE) & rst_n. out_valid = (state == OUT).
- IDLE:
  - Accept when in_valid & in_ready.
  - On accept, capture `in` into the share register and load the accumulator with share 0 of every bit.
  - Set the counter k = 1.
  - Next state: ACC if d > 1, else OUT, and the share register is zeroed.
- ACC, each cycle:
  - accumulator ^= share k of every bit; k <= k + 1.
  - When k == d-1, go to OUT in the same edge and zero the share register.
  - The counter width is clog2(d), minimum 1 bit; k never exceeds d-1.
- OUT:
  - out = accumulator; hold out and out_valid stable while out_ready = 0.
  - On out_ready = 1, go to IDLE, clear the accumulator, and drive out = 0 next cycle.
- out is 0 whenever out_valid = 0; decoded data is never exposed early.
- Latency: accept in cycle t gives first out_valid in cycle t+d (d = 1: t+1).
- Throughput: one transaction per d+1 cycles with out_ready held high. No overlap: in_ready is low in ACC and OUT, so there is no simultaneous in/out handshake.
- in_valid while not ready is ignored, with no side effects. `in` may change freely when not accepted.
- out_ready outside OUT is ignored.
- d = 1 degenerates to a one-cycle buffer (ACC is never entered).
- Share register zeroization at the ACC→OUT transition is mandatory: no share residue may remain after decoding.

Test Plan:
- Reset check, d=3, count=4:
  - Hold rst_n = 0 for 2 cycles.
  - Required: in_ready = 0, then after release in_ready = 1, out_valid = 0, out = 4'h0.
- Single decode, d=3, count=4, shares A, 5, 3 per nibble (packed i*d+j):
  - Accept in cycle t.
  - Required: out_valid rises in cycle t+3 with out = 4'hC.
  - Required: in_ready low in cycles t+1..t+3, back high after the out_ready handshake.
- Backpressure:
  - Same transaction, out_ready = 0 for 5 cycles then 1.
  - Required: out = 4'hC and out_valid stable all 5 cycles.
  - Required: IDLE next cycle with out = 0, and a new in_valid ignored while in OUT.
- Back-to-back, d=2, count=1, out_ready = 1:
  - Stream sharings (1,0), (1,1), (0,1).
  - Required: outputs 1, 0, 1, one accept every 3 cycles.
- Reset mid-ACC, d=4, count=8:
  - Pull rst_n low at cycle t+2 after accept.
  - Required: no out_valid pulse; share register and accumulator read 0.
  - Required: the next sharing 8'hFF, 8'h0F, 8'hF0, 8'h00 decodes to 8'h00.
- Degenerate d=1, count=8:
  - Accept 8'h5A.
  - Required: out_valid in cycle t+1 with out = 8'h5A; ACC is never visited.
